// File: rtl/codec_cfg_sequencer_if.sv
// Purpose: request/response bundle between the codec config sequencer and
//          its neighbours (user request sources and the WM8960 init block).
// Signals:
//   vol_up, vol_down, micb_toggle, bclk_sel, bclk_sel_vld : user requests
//   Init_Done                                             : init block status
//   Init_Go, vol_Go, MICB_Go, BCLK_Go                     : one-cycle requests
//   volume_8, MICB_Power, BCLK_ctrl                       : applied values
//   busy, cfg_error                                       : sequencer status
// Modports: master = sequencer side, slave = environment side.
interface codec_cfg_sequencer_if;
  localparam int unsigned VOL_W  = 8;
  localparam int unsigned BCLK_W = 4;

  logic              vol_up;
  logic              vol_down;
  logic              micb_toggle;
  logic [BCLK_W-1:0] bclk_sel;
  logic              bclk_sel_vld;
  logic              Init_Done;
  logic              Init_Go;
  logic              vol_Go;
  logic              MICB_Go;
  logic              BCLK_Go;
  logic [VOL_W-1:0]  volume_8;
  logic              MICB_Power;
  logic [BCLK_W-1:0] BCLK_ctrl;
  logic              busy;
  logic              cfg_error;

  modport master (
    input  vol_up, vol_down, micb_toggle, bclk_sel, bclk_sel_vld, Init_Done,
    output Init_Go, vol_Go, MICB_Go, BCLK_Go,
    output volume_8, MICB_Power, BCLK_ctrl, busy, cfg_error
  );

  modport slave (
    output vol_up, vol_down, micb_toggle, bclk_sel, bclk_sel_vld, Init_Done,
    input  Init_Go, vol_Go, MICB_Go, BCLK_Go,
    input  volume_8, MICB_Power, BCLK_ctrl, busy, cfg_error
  );
endinterface

// File: rtl/codec_cfg_sequencer.sv
// Purpose: collects power-on, volume, mic-bias and BCLK configuration requests
//          and serializes them into mutually exclusive one-cycle Go pulses for
//          the WM8960 I2C init block, holding the value buses stable until
//          the init block reports Init_Done.
// Ports:
//   Clk   : system clock
//   Rst_n : synchronous active-low reset
//   bus   : codec_cfg_sequencer_if.master (requests in, Go/values/status out)
// Optional feature: define CFG_SEQ_TIMEOUT_EN to enable the per-transaction
//   watchdog (sticky cfg_error plus forced re-init). Without it cfg_error is 0.
module codec_cfg_sequencer #(
  parameter int unsigned POWERUP_DLY = 500000,
  parameter int unsigned TIMEOUT_CYC = 2000000,
  parameter logic [7:0]  VOL_MIN     = 8'h30,
  parameter logic [7:0]  VOL_MAX     = 8'h7F,
  parameter logic [7:0]  VOL_STEP    = 8'd4,
  parameter logic [7:0]  VOL_DEFAULT = 8'h79
) (
  input logic                   Clk,
  input logic                   Rst_n,
  codec_cfg_sequencer_if.master bus
);
  localparam int unsigned VOL_W  = 8;
  localparam int unsigned BCLK_W = 4;
  localparam int unsigned PWR_W  = (POWERUP_DLY > 1) ? $clog2(POWERUP_DLY) : 1;

  typedef enum logic [1:0] {S_PWR, S_IDLE, S_WLOW, S_WHIGH} state_e;

  state_e             state_q, state_d;
  logic [PWR_W-1:0]   pwr_cnt_q, pwr_cnt_d;
  logic [VOL_W-1:0]   vol_sh_q, vol_sh_d;
  logic               micb_sh_q, micb_sh_d;
  logic [BCLK_W-1:0]  bclk_sh_q, bclk_sh_d;
  logic               init_p_q, init_p_d;
  logic               bclk_p_q, bclk_p_d;
  logic               micb_p_q, micb_p_d;
  logic               vol_p_q, vol_p_d;
  logic               init_go_q, init_go_d;
  logic               vol_go_q, vol_go_d;
  logic               micb_go_q, micb_go_d;
  logic               bclk_go_q, bclk_go_d;
  logic [VOL_W-1:0]   volume_q, volume_d;
  logic               micb_pwr_q, micb_pwr_d;
  logic [BCLK_W-1:0]  bclk_ctrl_q, bclk_ctrl_d;
  logic               busy_q, busy_d;

  logic               init_set, clr_init, clr_bclk, clr_micb, clr_vol;

`ifdef CFG_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               err_q, err_d;
`endif

  // Clamped volume candidates, computed one bit wider so they never wrap.
  logic [VOL_W:0]     vol_inc, vol_dec;
  logic [VOL_W-1:0]   vol_up_val, vol_dn_val, vol_cand;
  logic               vol_set;

  assign vol_inc    = {1'b0, vol_sh_q} + (VOL_W+1)'(VOL_STEP);
  assign vol_dec    = {1'b0, vol_sh_q} - (VOL_W+1)'(VOL_STEP);
  assign vol_up_val = (vol_inc > {1'b0, VOL_MAX}) ? VOL_MAX : vol_inc[VOL_W-1:0];
  assign vol_dn_val = (vol_dec[VOL_W] || (vol_dec < {1'b0, VOL_MIN})) ? VOL_MIN
                                                                       : vol_dec[VOL_W-1:0];
  assign vol_cand   = bus.vol_up ? vol_up_val : vol_dn_val;
  // Simultaneous up/down cancels; a press already at the clamp is ignored.
  assign vol_set    = (bus.vol_up ^ bus.vol_down) && (vol_cand != vol_sh_q);

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= S_PWR;
      pwr_cnt_q   <= '0;
      vol_sh_q    <= VOL_DEFAULT;
      micb_sh_q   <= 1'b0;
      bclk_sh_q   <= '0;
      init_p_q    <= 1'b0;
      bclk_p_q    <= 1'b0;
      micb_p_q    <= 1'b0;
      vol_p_q     <= 1'b0;
      init_go_q   <= 1'b0;
      vol_go_q    <= 1'b0;
      micb_go_q   <= 1'b0;
      bclk_go_q   <= 1'b0;
      volume_q    <= VOL_DEFAULT;
      micb_pwr_q  <= 1'b0;
      bclk_ctrl_q <= '0;
      busy_q      <= 1'b0;
`ifdef CFG_SEQ_TIMEOUT_EN
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      vol_sh_q    <= vol_sh_d;
      micb_sh_q   <= micb_sh_d;
      bclk_sh_q   <= bclk_sh_d;
      init_p_q    <= init_p_d;
      bclk_p_q    <= bclk_p_d;
      micb_p_q    <= micb_p_d;
      vol_p_q     <= vol_p_d;
      init_go_q   <= init_go_d;
      vol_go_q    <= vol_go_d;
      micb_go_q   <= micb_go_d;
      bclk_go_q   <= bclk_go_d;
      volume_q    <= volume_d;
      micb_pwr_q  <= micb_pwr_d;
      bclk_ctrl_q <= bclk_ctrl_d;
      busy_q      <= busy_d;
`ifdef CFG_SEQ_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  // Next-state, shadow capture, issue arbitration and pending bookkeeping.
  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    vol_sh_d    = vol_sh_q;
    micb_sh_d   = micb_sh_q;
    bclk_sh_d   = bclk_sh_q;
    init_go_d   = 1'b0;
    vol_go_d    = 1'b0;
    micb_go_d   = 1'b0;
    bclk_go_d   = 1'b0;
    volume_d    = volume_q;
    micb_pwr_d  = micb_pwr_q;
    bclk_ctrl_d = bclk_ctrl_q;
    init_set    = 1'b0;
    clr_init    = 1'b0;
    clr_bclk    = 1'b0;
    clr_micb    = 1'b0;
    clr_vol     = 1'b0;
`ifdef CFG_SEQ_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;
`endif

    // Shadows take requests in every state, including the issue cycle.
    if (vol_set)          vol_sh_d  = vol_cand;
    if (bus.micb_toggle)  micb_sh_d = ~micb_sh_q;
    if (bus.bclk_sel_vld) bclk_sh_d = bus.bclk_sel;

    case (state_q)
      S_PWR: begin
        pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
        if (pwr_cnt_q == PWR_W'(POWERUP_DLY - 1)) begin
          init_set = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_IDLE: begin
        // Outputs load from the pre-update shadows on the same edge as Go.
        if (init_p_q) begin
          init_go_d   = 1'b1;
          volume_d    = vol_sh_q;
          micb_pwr_d  = micb_sh_q;
          bclk_ctrl_d = bclk_sh_q;
          clr_init    = 1'b1;
          clr_bclk    = 1'b1;
          clr_micb    = 1'b1;
          clr_vol     = 1'b1;
        end else if (bclk_p_q) begin
          bclk_go_d   = 1'b1;
          bclk_ctrl_d = bclk_sh_q;
          clr_bclk    = 1'b1;
        end else if (micb_p_q) begin
          micb_go_d   = 1'b1;
          micb_pwr_d  = micb_sh_q;
          clr_micb    = 1'b1;
        end else if (vol_p_q) begin
          vol_go_d    = 1'b1;
          volume_d    = vol_sh_q;
          clr_vol     = 1'b1;
        end
        if (init_p_q || bclk_p_q || micb_p_q || vol_p_q) begin
          state_d = S_WLOW;
`ifdef CFG_SEQ_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      S_WLOW: begin
        if (!bus.Init_Done) state_d = S_WHIGH;
      end
      S_WHIGH: begin
        if (bus.Init_Done) state_d = S_IDLE;
      end
      default: state_d = S_PWR;
    endcase

`ifdef CFG_SEQ_TIMEOUT_EN
    // Watchdog: abandon a stuck transaction and force a full re-init.
    if ((state_q == S_WLOW) || (state_q == S_WHIGH)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
        err_d    = 1'b1;
        init_set = 1'b1;
        state_d  = S_IDLE;
      end
    end
`endif

    // A request in the issue cycle re-arms its flag after the clear.
    init_p_d = (init_p_q & ~clr_init) | init_set;
    bclk_p_d = (bclk_p_q & ~clr_bclk) | bus.bclk_sel_vld;
    micb_p_d = (micb_p_q & ~clr_micb) | bus.micb_toggle;
    vol_p_d  = (vol_p_q  & ~clr_vol)  | vol_set;

    busy_d = (state_d == S_WLOW) || (state_d == S_WHIGH);
  end

  assign bus.Init_Go    = init_go_q;
  assign bus.vol_Go     = vol_go_q;
  assign bus.MICB_Go    = micb_go_q;
  assign bus.BCLK_Go    = bclk_go_q;
  assign bus.volume_8   = volume_q;
  assign bus.MICB_Power = micb_pwr_q;
  assign bus.BCLK_ctrl  = bclk_ctrl_q;
  assign bus.busy       = busy_q;
`ifdef CFG_SEQ_TIMEOUT_EN
  assign bus.cfg_error  = err_q;
`else
  assign bus.cfg_error  = 1'b0;
`endif

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Purpose: self-checking bench for codec_cfg_sequencer with a behavioural
//          init-block model (Init_Done drops 2 cycles after a Go, rises 20
//          cycles later). Table-driven single requests plus hand sequences
//          for power-up, coalescing, priority, clamps, timeout and reset.
`timescale 1ns/1ps
module tb_codec_cfg_sequencer;
  localparam int unsigned PDLY = 10;
  localparam int unsigned TCYC = 50;
  localparam int K_NONE = 0;
  localparam int K_INIT = 1;
  localparam int K_BCLK = 2;
  localparam int K_MICB = 3;
  localparam int K_VOL  = 4;

  logic Clk;
  logic Rst_n;
  logic hold_low;
  int   n_run;
  int   n_fail;

  codec_cfg_sequencer_if bus();

  codec_cfg_sequencer #(
    .POWERUP_DLY(PDLY),
    .TIMEOUT_CYC(TCYC)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Init-block model.
  logic go_any;
  logic m_active;
  int   m_cnt;
  assign go_any = bus.Init_Go | bus.vol_Go | bus.MICB_Go | bus.BCLK_Go;

  always @(posedge Clk) begin
    if (!Rst_n) begin
      m_active      <= 1'b0;
      m_cnt         <= 0;
      bus.Init_Done <= 1'b1;
    end else if (go_any) begin
      m_active <= 1'b1;
      m_cnt    <= 1;
    end else if (m_active) begin
      if (m_cnt == 1) bus.Init_Done <= 1'b0;
      if (m_cnt >= 21 && !hold_low) begin
        bus.Init_Done <= 1'b1;
        m_active      <= 1'b0;
      end else if (m_cnt < 21) begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Protocol monitor: one-hot single-cycle Go, outputs frozen while busy.
  logic        rst_seen;
  logic [3:0]  prev_gos = 4'b0;
  logic        prev_busy = 1'b0;
  logic [12:0] prev_out = '0;
  logic [3:0]  m_gos;
  logic [12:0] m_outs;
  always @(posedge Clk) rst_seen <= Rst_n;
  always @(negedge Clk) begin
    m_gos  = {bus.Init_Go, bus.BCLK_Go, bus.MICB_Go, bus.vol_Go};
    m_outs = {bus.volume_8, bus.MICB_Power, bus.BCLK_ctrl};
    if (rst_seen === 1'b1) begin
      if (m_gos != 4'b0) begin
        n_run++;
        if ($countones(m_gos) != 1 || prev_gos != 4'b0) begin
          n_fail++;
          $display("FAIL go_pulse: gos=%b prev=%b, required one-hot and one cycle wide", m_gos, prev_gos);
        end
      end
      if (prev_busy) begin
        n_run++;
        if (m_outs != prev_out) begin
          n_fail++;
          $display("FAIL out_stable: outputs %h changed from %h while busy", m_outs, prev_out);
        end
      end
    end
    prev_gos  = m_gos;
    prev_busy = bus.busy;
    prev_out  = m_outs;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_go(input int budget, output int kind, output int cyc);
    kind = K_NONE;
    cyc  = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      cyc++;
      if (bus.Init_Go)      kind = K_INIT;
      else if (bus.BCLK_Go) kind = K_BCLK;
      else if (bus.MICB_Go) kind = K_MICB;
      else if (bus.vol_Go)  kind = K_VOL;
      if (kind != K_NONE) break;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      step();
      n++;
    end
    n_run++;
    if (bus.busy) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, expected 0", name, bus.busy, n);
    end
  endtask

  task automatic pulse(input logic up, input logic dn, input logic mt,
                       input logic bv, input logic [3:0] bs);
    bus.vol_up       = up;
    bus.vol_down     = dn;
    bus.micb_toggle  = mt;
    bus.bclk_sel_vld = bv;
    bus.bclk_sel     = bs;
    step();
    bus.vol_up       = 1'b0;
    bus.vol_down     = 1'b0;
    bus.micb_toggle  = 1'b0;
    bus.bclk_sel_vld = 1'b0;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_vol"},  bus.volume_8, 8'h79);
    chk({name, "_micb"}, bus.MICB_Power, 1'b0);
    chk({name, "_bclk"}, bus.BCLK_ctrl, 4'h0);
    chk({name, "_busy"}, bus.busy, 1'b0);
    chk({name, "_gos"},  {bus.Init_Go, bus.BCLK_Go, bus.MICB_Go, bus.vol_Go}, 4'b0);
    chk({name, "_err"},  bus.cfg_error, 1'b0);
  endtask

  typedef struct {
    logic       up;
    logic       dn;
    logic       mt;
    logic       bv;
    logic [3:0] bs;
    int         kind;
    logic [7:0] vol;
    logic       micb;
    logic [3:0] bclk;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int kind, cyc, nb, first, ngo;
    logic [7:0] fv;

    // Starting point: vol 77, micb 1, bclk 3 (end of the priority sequence).
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, K_NONE, 8'h77, 1'b1, 4'h3};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, K_VOL,  8'h73, 1'b1, 4'h3};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, K_MICB, 8'h73, 1'b0, 4'h3};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hA, K_BCLK, 8'h73, 1'b0, 4'hA};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'hA, K_BCLK, 8'h73, 1'b0, 4'hA};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, K_VOL,  8'h77, 1'b0, 4'hA};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, K_VOL,  8'h7B, 1'b0, 4'hA};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, K_VOL,  8'h7F, 1'b0, 4'hA};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, K_NONE, 8'h7F, 1'b0, 4'hA};

    n_run = 0;
    n_fail = 0;
    hold_low = 1'b0;
    bus.vol_up = 1'b0;
    bus.vol_down = 1'b0;
    bus.micb_toggle = 1'b0;
    bus.bclk_sel_vld = 1'b0;
    bus.bclk_sel = 4'h0;
    Rst_n = 1'b0;

    // Reset state and power-up init.
    repeat (3) step();
    chk_reset_vals("rst");
    Rst_n = 1'b1;
    wait_go(40, kind, cyc);
    chk("pwr_init_kind", kind, K_INIT);
    chk("pwr_init_cycle", cyc, PDLY + 1);
    chk("pwr_init_vol", bus.volume_8, 8'h79);
    chk("pwr_init_micb", bus.MICB_Power, 1'b0);
    chk("pwr_init_bclk", bus.BCLK_ctrl, 4'h0);
    nb = 0;
    while (bus.busy && nb < 100) begin
      nb++;
      step();
    end
    chk("pwr_busy_len", nb, 23);
    chk("pwr_done_high", bus.Init_Done, 1'b1);

    // Three back-to-back vol_up presses: 7D issued, then 7F coalesced.
    bus.vol_up = 1'b1;
    step();
    step();
    chk("up1_go", bus.vol_Go, 1'b1);
    chk("up1_vol", bus.volume_8, 8'h7D);
    step();
    bus.vol_up = 1'b0;
    wait_idle("up1");
    wait_go(5, kind, cyc);
    chk("up23_kind", kind, K_VOL);
    chk("up23_gap", cyc, 1);
    chk("up23_vol", bus.volume_8, 8'h7F);
    wait_idle("up23");
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    wait_go(10, kind, cyc);
    chk("up4_kind", kind, K_NONE);
    chk("up4_vol", bus.volume_8, 8'h7F);

    // Requests during a busy transaction are served in priority order.
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    wait_go(5, kind, cyc);
    chk("pri_vol0_kind", kind, K_VOL);
    chk("pri_vol0_val", bus.volume_8, 8'h7B);
    pulse(1'b0, 1'b1, 1'b1, 1'b1, 4'h3);
    chk("pri_busy", bus.busy, 1'b1);
    chk("pri_vol_held", bus.volume_8, 8'h7B);
    wait_idle("pri0");
    wait_go(5, kind, cyc);
    chk("pri_bclk_kind", kind, K_BCLK);
    chk("pri_bclk_val", bus.BCLK_ctrl, 4'h3);
    wait_idle("pri1");
    wait_go(5, kind, cyc);
    chk("pri_micb_kind", kind, K_MICB);
    chk("pri_micb_val", bus.MICB_Power, 1'b1);
    wait_idle("pri2");
    wait_go(5, kind, cyc);
    chk("pri_vol_kind", kind, K_VOL);
    chk("pri_vol_val", bus.volume_8, 8'h77);
    wait_idle("pri3");

    // Table of single requests from idle.
    for (int i = 0; i < 9; i++) begin
      pulse(vecs[i].up, vecs[i].dn, vecs[i].mt, vecs[i].bv, vecs[i].bs);
      wait_go(6, kind, cyc);
      chk($sformatf("vec%0d_kind", i), kind, vecs[i].kind);
      chk($sformatf("vec%0d_vol", i), bus.volume_8, vecs[i].vol);
      chk($sformatf("vec%0d_micb", i), bus.MICB_Power, vecs[i].micb);
      chk($sformatf("vec%0d_bclk", i), bus.BCLK_ctrl, vecs[i].bclk);
      if (kind != K_NONE) wait_idle($sformatf("vec%0d", i));
    end

    // Lower clamp: 22 consecutive vol_down presses from 7F.
    bus.vol_down = 1'b1;
    first = -1;
    ngo = 0;
    fv = 8'h00;
    for (int i = 0; i < 22; i++) begin
      step();
      if (go_any) begin
        ngo++;
        if (first < 0) begin
          first = i;
          fv = bus.volume_8;
        end
      end
    end
    bus.vol_down = 1'b0;
    chk("min_go_count", ngo, 1);
    chk("min_first_idx", first, 1);
    chk("min_first_vol", fv, 8'h7B);
    wait_idle("min0");
    wait_go(5, kind, cyc);
    chk("min_kind", kind, K_VOL);
    chk("min_vol", bus.volume_8, 8'h30);
    wait_idle("min1");
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    wait_go(10, kind, cyc);
    chk("min_again_kind", kind, K_NONE);
    chk("min_again_vol", bus.volume_8, 8'h30);

`ifdef CFG_SEQ_TIMEOUT_EN
    // Init block never completes: watchdog fires and forces a re-init.
    hold_low = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    wait_go(5, kind, cyc);
    chk("to_micb_kind", kind, K_MICB);
    nb = 0;
    while (bus.busy && nb < 200) begin
      nb++;
      step();
    end
    chk("to_busy_len", nb, TCYC);
    chk("to_err", bus.cfg_error, 1'b1);
    hold_low = 1'b0;
    wait_go(5, kind, cyc);
    chk("to_reinit_kind", kind, K_INIT);
    wait_idle("to");
    chk("to_err_sticky", bus.cfg_error, 1'b1);
`endif

    // Reset in the middle of a transaction (waiting for Init_Done high).
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    wait_go(5, kind, cyc);
    chk("mid_micb_kind", kind, K_MICB);
    repeat (6) step();
    chk("mid_busy", bus.busy, 1'b1);
    chk("mid_done_low", bus.Init_Done, 1'b0);
    Rst_n = 1'b0;
    step();
    chk_reset_vals("mid_rst");
    Rst_n = 1'b1;
    wait_go(40, kind, cyc);
    chk("mid_init_kind", kind, K_INIT);
    chk("mid_init_cycle", cyc, PDLY + 1);
    chk("mid_init_vol", bus.volume_8, 8'h79);
    chk("mid_init_micb", bus.MICB_Power, 1'b0);
    chk("mid_init_bclk", bus.BCLK_ctrl, 4'h0);
    wait_idle("mid");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/codec_cfg_sequencer.md
# codec_cfg_sequencer

Request sequencer sitting directly upstream of the WM8960 I2C register-init block. Collects user and system configuration requests: power-on init, volume up/down, mic-bias toggle and BCLK divider select. Serializes them into mutually exclusive single-cycle `Init_Go` / `vol_Go` / `MICB_Go` / `BCLK_Go` pulses, and holds the value buses (`volume_8`, `MICB_Power`, `BCLK_ctrl`) stable until the init block reports `Init_Done`.

## Interface
Parameters:
- `POWERUP_DLY`, 500000: cycles from reset release to the automatic init request (10 ms at 50 MHz).
- `TIMEOUT_CYC`, 2000000: watchdog limit per transaction, in cycles.
- `VOL_MIN`, 8'h30: lower volume clamp.
- `VOL_MAX`, 8'h7F: upper volume clamp.
- `VOL_STEP`, 8'd4: volume increment/decrement per press.
- `VOL_DEFAULT`, 8'h79: volume after reset.

Ports:
- `Clk` in 1: system clock, single clock domain.
- `Rst_n` in 1: reset, synchronous, active-low.
- `vol_up` in 1: one-cycle pulse; raise volume by one step.
- `vol_down` in 1: one-cycle pulse; lower volume by one step.
- `micb_toggle` in 1: one-cycle pulse; invert the mic-bias request.
- `bclk_sel` in 4: requested BCLK divider code.
- `bclk_sel_vld` in 1: one-cycle strobe; samples `bclk_sel`.
- `Init_Done` in 1: completion flag from the init block.
- `Init_Go`, `vol_Go`, `MICB_Go`, `BCLK_Go` out 1 each: one-cycle request pulses to the init block.
- `volume_8` out 8: applied volume.
- `MICB_Power` out 1: applied mic-bias enable.
- `BCLK_ctrl` out 4: applied BCLK code.
- `busy` out 1: a transaction is in flight.
- `cfg_error` out 1: sticky timeout flag.

## Operation
- Shadow registers `vol_sh`, `micb_sh` and `bclk_sh` accept requests at any time. Output registers are loaded from the shadows only at issue.
- Volume requests:
  - `vol_up` sets `vol_sh = min(vol_sh+VOL_STEP, VOL_MAX)`; `vol_down` sets `vol_sh = max(vol_sh-VOL_STEP, VOL_MIN)`.
  - Compute in 9 bits so the result never wraps.
  - `vol_up` and `vol_down` in the same cycle: no change, no pending.
  - A press that leaves `vol_sh` unchanged (already clamped) sets no pending.
- Pending flags `init_p`, `bclk_p`, `micb_p` and `vol_p` are set by their requests. Multiple requests of one kind coalesce into a single flag.
- `micb_toggle` always sets `micb_p`, even when two toggles cancel out.
- FSM states:
  - `S_PWR`: count `POWERUP_DLY` cycles, then set `init_p` and go to `S_IDLE`. Requests arriving in `S_PWR` update the shadows and pendings.
  - `S_IDLE`: if any flag is pending, issue the highest priority: init > bclk > micb > vol. On issue, load the outputs from the shadows, pulse the matching Go, clear that flag, go to `S_WLOW`. An init issue loads all three outputs and clears all four flags.
  - `S_WLOW`: wait for `Init_Done == 0` (the init block clears it two cycles after the Go pulse), then go to `S_WHIGH`.
  - `S_WHIGH`: wait for `Init_Done == 1`, then go to `S_IDLE`.
- `busy` = 1 in `S_WLOW` and `S_WHIGH`.

## Timing
- Reset values:
  - All Go outputs = 0, `busy` = 0, `cfg_error` = 0.
  - `volume_8` = `VOL_DEFAULT`, `MICB_Power` = 0, `BCLK_ctrl` = 4'd0; shadows match the outputs.
  - Pending flags clear; state = `S_PWR`.
- Issue cycle: Go and the output values change on the same clock edge, so the value buses are valid when Go is seen.
- At most one Go is high in any cycle; each Go is high for exactly one cycle.
- After any transaction completes there is at least one `S_IDLE` cycle before the next Go pulse.
- Requests arriving in the issue cycle land in the shadows and pendings and are served by a later transaction. The in-flight output values are never disturbed.
- `Rst_n` low mid-transaction: all state is restored to reset values on the next edge, with no Go pulse. The power-up delay restarts.

## Configuration
- `CFG_SEQ_TIMEOUT_EN` defined:
  - A counter runs in `S_WLOW` and `S_WHIGH` and clears on entry to `S_WLOW`.
  - When it reaches `TIMEOUT_CYC`, set `cfg_error` (sticky until reset), set `init_p` to force a full re-init, and go to `S_IDLE`.
- Not defined: no counter. The FSM waits indefinitely, `cfg_error` is tied to 0, and no timeout logic is generated.

## Test plan
All scenarios use `POWERUP_DLY`=10 and `TIMEOUT_CYC`=50, with a behavioural init-block model: `Init_Done` drops 2 cycles after Go and rises 20 cycles later.
- Reset release, no inputs -> exactly one `Init_Go` at cycle 10 with `volume_8`=8'h79, `MICB_Power`=0, `BCLK_ctrl`=0. `busy` lasts until the model raises `Init_Done`.
- After init, 3 `vol_up` pulses while idle:
  - The first press produces `vol_Go` with `volume_8`=8'h7D.
  - The second and third coalesce into one further `vol_Go` with `volume_8`=8'h7F (clamped).
  - A fourth press produces no Go.
- During a busy `vol_Go` transaction, send `bclk_sel_vld` with `bclk_sel`=4'h3, `micb_toggle`, and `vol_down` -> after completion: `BCLK_Go` (`BCLK_ctrl`=3), then `MICB_Go` (`MICB_Power`=1), then `vol_Go`. Outputs are never changed while `busy`.
- `vol_up` and `vol_down` in the same cycle -> no pending, no Go, `volume_8` unchanged.
- With `CFG_SEQ_TIMEOUT_EN` defined and the model holding `Init_Done`=0 after a `MICB_Go` -> `cfg_error`=1 after 50 busy cycles, followed by an `Init_Go` re-init.
- Drive `Rst_n`=0 for one cycle in `S_WHIGH` -> all outputs return to reset values on the next edge, and a fresh `Init_Go` follows 10 cycles after release.
